// File: rtl/acc_cond.sv
// Accelerometer sample conditioner: averages 2^CALIB_LOG2 samples at rest into a bias,
// then outputs bias-corrected, saturated and deadbanded samples to the integrator.
module acc_cond #(
  parameter int unsigned CALIB_LOG2 = 8,
  parameter logic [15:0] DEADBAND   = 16'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_raw_in,
  input  logic        i_raw_valid,
  input  logic        i_recal,
  output logic [15:0] o_acc_out,
  output logic        o_acc_valid,
  output logic        o_calib_done,
  output logic [15:0] o_bias_out
);

  localparam int unsigned ACC_W = 16 + CALIB_LOG2;

  localparam logic [0:0] ST_CALIB = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            r_state;
  logic [ACC_W-1:0]      r_acc;
  logic [CALIB_LOG2-1:0] r_cnt;
  logic [15:0]           r_acc_out;
  logic                  r_acc_valid;
  logic                  r_calib_done;
  logic [15:0]           r_bias;

  logic [ACC_W-1:0]      w_raw_ext;
  logic [ACC_W-1:0]      w_sum;
  logic [15:0]           w_bias_new;
  logic                  w_last;
  logic [16:0]           w_diff;
  logic [16:0]           w_diff_mag;
  logic [15:0]           w_sat;
  logic [15:0]           w_cond;

  logic [0:0]            w_state_nxt;
  logic [ACC_W-1:0]      w_acc_nxt;
  logic [CALIB_LOG2-1:0] w_cnt_nxt;
  logic [15:0]           w_acc_out_nxt;
  logic                  w_acc_valid_nxt;
  logic                  w_calib_done_nxt;
  logic [15:0]           w_bias_nxt;

  // Calibration datapath
  assign w_raw_ext = {{CALIB_LOG2{i_raw_in[15]}}, i_raw_in};
  assign w_sum     = r_acc + w_raw_ext;
  // Top 16 bits of the sum equal sum >>> CALIB_LOG2 (floor division by 2^CALIB_LOG2).
  assign w_bias_new = w_sum[ACC_W-1 -: 16];
  assign w_last     = &r_cnt;

  // Run datapath: 17-bit difference, saturation, deadband on the true magnitude
  assign w_diff     = {i_raw_in[15], i_raw_in} - {r_bias[15], r_bias};
  assign w_diff_mag = w_diff[16] ? (17'd0 - w_diff) : w_diff;

  always_comb begin
    if (w_diff[16] != w_diff[15]) begin
      w_sat = w_diff[16] ? 16'h8000 : 16'h7fff;
    end else begin
      w_sat = w_diff[15:0];
    end
  end

  assign w_cond = (w_diff_mag <= {1'b0, DEADBAND}) ? 16'h0000 : w_sat;

  // Next-state logic; recal overrides any concurrent sample
  always_comb begin
    w_state_nxt      = r_state;
    w_acc_nxt        = r_acc;
    w_cnt_nxt        = r_cnt;
    w_acc_out_nxt    = r_acc_out;
    w_acc_valid_nxt  = 1'b0;
    w_calib_done_nxt = r_calib_done;
    w_bias_nxt       = r_bias;

    if (i_recal) begin
      w_state_nxt      = ST_CALIB;
      w_acc_nxt        = '0;
      w_cnt_nxt        = '0;
      w_acc_out_nxt    = 16'h0000;
      w_calib_done_nxt = 1'b0;
    end else if (i_raw_valid) begin
      if (r_state == ST_CALIB) begin
        if (w_last) begin
          w_bias_nxt       = w_bias_new;
          w_acc_nxt        = '0;
          w_cnt_nxt        = '0;
          w_calib_done_nxt = 1'b1;
          w_state_nxt      = ST_RUN;
        end else begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = r_cnt + CALIB_LOG2'(1);
        end
      end else begin
        w_acc_out_nxt   = w_cond;
        w_acc_valid_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_CALIB;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_acc_out    <= 16'h0000;
      r_acc_valid  <= 1'b0;
      r_calib_done <= 1'b0;
      r_bias       <= 16'h0000;
    end else begin
      r_state      <= w_state_nxt;
      r_acc        <= w_acc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_acc_out    <= w_acc_out_nxt;
      r_acc_valid  <= w_acc_valid_nxt;
      r_calib_done <= w_calib_done_nxt;
      r_bias       <= w_bias_nxt;
    end
  end

  assign o_acc_out    = r_acc_out;
  assign o_acc_valid  = r_acc_valid;
  assign o_calib_done = r_calib_done;
  assign o_bias_out   = r_bias;

endmodule

// File: tb/tb_acc_cond.sv
// Directed bench for acc_cond with CALIB_LOG2=2, DEADBAND=8; conditioned outputs are
// checked against a scoreboard filled by a small behavioural model at drive time.
module tb_acc_cond;

  logic        clk;
  logic        reset;
  logic [15:0] i_raw_in;
  logic        i_raw_valid;
  logic        i_recal;
  logic [15:0] o_acc_out;
  logic        o_acc_valid;
  logic        o_calib_done;
  logic [15:0] o_bias_out;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sb[$];
  int          m_sum;
  int          m_cnt;
  int          m_bias;
  bit          m_run;

  acc_cond #(
    .CALIB_LOG2(2),
    .DEADBAND  (16'd8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_raw_in    (i_raw_in),
    .i_raw_valid (i_raw_valid),
    .i_recal     (i_recal),
    .o_acc_out   (o_acc_out),
    .o_acc_valid (o_acc_valid),
    .o_calib_done(o_calib_done),
    .o_bias_out  (o_bias_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_cond(input int raw, input int bias);
    int d;
    d = raw - bias;
    if (d > 32767) d = 32767;
    else if (d < -32768) d = -32768;
    if (d <= 8 && d >= -8) d = 0;
    return 16'(d);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0;
    m_cnt = 0;
    m_run = 0;
  endtask

  task automatic send(input int v);
    i_raw_in    = 16'(v);
    i_raw_valid = 1'b1;
    if (m_run) begin
      sb.push_back(model_cond(v, m_bias));
    end else begin
      m_sum += v;
      m_cnt++;
      if (m_cnt == 4) begin
        m_bias = m_sum >>> 2;
        m_run  = 1;
        m_sum  = 0;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
    i_raw_valid = 1'b0;
  endtask

  task automatic do_recal(input bit with_valid, input int v);
    i_recal     = 1'b1;
    i_raw_valid = with_valid;
    i_raw_in    = 16'(v);
    model_clear();
    @(posedge clk);
    #1;
    i_recal     = 1'b0;
    i_raw_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every acc_valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (o_acc_valid === 1'b1) begin
      chk("sb_pending", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) chk("sb_acc_out", o_acc_out, sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    i_raw_in    = 16'h0000;
    i_raw_valid = 1'b0;
    i_recal     = 1'b0;
    model_clear();
    m_bias = 0;
    idle(2);
    chk("rst_acc_out", o_acc_out, 16'h0000);
    chk("rst_acc_valid", 16'(o_acc_valid), 16'd0);
    chk("rst_calib_done", 16'(o_calib_done), 16'd0);
    chk("rst_bias", o_bias_out, 16'h0000);
    reset = 1'b0;
    idle(1);

    // Basic calibration, back-to-back samples
    send(100);
    send(102);
    send(98);
    chk("cal3_not_done", 16'(o_calib_done), 16'd0);
    send(104);
    chk("cal_done", 16'(o_calib_done), 16'd1);
    chk("cal_bias", o_bias_out, 16'd101);
    chk("cal_no_valid", 16'(o_acc_valid), 16'd0);
    chk("cal_acc_zero", o_acc_out, 16'h0000);

    send(200);
    chk("run_valid", 16'(o_acc_valid), 16'd1);
    chk("run_out", o_acc_out, 16'd99);
    idle(3);
    chk("hold_out", o_acc_out, 16'd99);
    chk("hold_no_valid", 16'(o_acc_valid), 16'd0);

    // Deadband edges
    send(109);
    send(93);
    send(110);
    send(92);
    idle(1);
    chk("db_neg_hold", o_acc_out, 16'hfff7);

    // Recal mid-run with a concurrent sample that must be dropped
    send(200);
    do_recal(1'b1, 555);
    chk("recal_acc_out", o_acc_out, 16'h0000);
    chk("recal_valid", 16'(o_acc_valid), 16'd0);
    chk("recal_done", 16'(o_calib_done), 16'd0);
    chk("recal_bias_kept", o_bias_out, 16'd101);
    send(50);
    send(50);
    send(50);
    chk("recal3_not_done", 16'(o_calib_done), 16'd0);
    send(50);
    chk("recal_bias", o_bias_out, 16'd50);
    chk("recal_done_set", 16'(o_calib_done), 16'd1);

    // Continuous valid in RUN
    send(60);
    chk("cont_valid0", 16'(o_acc_valid), 16'd1);
    send(70);
    chk("cont_valid1", 16'(o_acc_valid), 16'd1);
    send(80);
    chk("cont_valid2", 16'(o_acc_valid), 16'd1);
    send(90);
    chk("cont_valid3", 16'(o_acc_valid), 16'd1);
    send(40);
    chk("cont_valid4", 16'(o_acc_valid), 16'd1);
    chk("cont_out_neg", o_acc_out, 16'hfff6);
    idle(1);

    // Positive saturation
    do_recal(1'b0, 0);
    for (int i = 0; i < 4; i++) send(-32768);
    chk("satp_bias", o_bias_out, 16'h8000);
    send(32767);
    chk("satp_out", o_acc_out, 16'h7fff);

    // Negative saturation
    do_recal(1'b0, 0);
    for (int i = 0; i < 4; i++) send(32767);
    chk("satn_bias", o_bias_out, 16'h7fff);
    send(-32768);
    chk("satn_out", o_acc_out, 16'h8000);

    // Negative bias rounds toward minus infinity
    do_recal(1'b0, 0);
    send(-1);
    send(-1);
    send(-1);
    send(-2);
    chk("neg_bias", o_bias_out, 16'hfffe);
    send(0);
    send(20);
    chk("neg_out", o_acc_out, 16'd22);

    // Asynchronous reset mid-calibration
    do_recal(1'b0, 0);
    send(10);
    send(10);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_bias", o_bias_out, 16'h0000);
    chk("arst_acc_out", o_acc_out, 16'h0000);
    chk("arst_done", 16'(o_calib_done), 16'd0);
    chk("arst_valid", 16'(o_acc_valid), 16'd0);
    model_clear();
    m_bias = 0;
    #2;
    reset = 1'b0;
    send(12);
    send(12);
    send(12);
    chk("arst3_not_done", 16'(o_calib_done), 16'd0);
    send(12);
    chk("arst_cal_done", 16'(o_calib_done), 16'd1);
    chk("arst_cal_bias", o_bias_out, 16'd12);
    send(30);
    chk("arst_run_out", o_acc_out, 16'd18);

    idle(2);
    chk("sb_drain", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_cond.md
# acc_cond

Accelerometer sample conditioner that sits directly upstream of the position/velocity integrator. It takes raw signed 16-bit accelerometer samples from the sensor interface and averages the first 2^CALIB_LOG2 samples at rest to obtain a bias. After calibration it subtracts that bias from every sample, applies a symmetric deadband and saturates. The result is presented as a held 16-bit signed value that the integrator samples every clock.

## Interface
- CALIB_LOG2, 8, log2 of the number of samples averaged for bias calibration (range 1..16)
- DEADBAND, 16'd8, unsigned magnitude; bias-corrected values with |diff| <= DEADBAND are forced to 0
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- raw_in  input  16  raw signed acceleration sample, valid only when raw_valid=1
- raw_valid  input  1  one-cycle strobe per sample; may be high on consecutive cycles
- recal  input  1  one-cycle request to restart calibration
- acc_out  output  16  conditioned signed acceleration, held between samples; drives the integrator's acc_in
- acc_valid  output  1  one-cycle pulse when acc_out is updated
- calib_done  output  1  high once a valid bias exists and the block is in RUN
- bias_out  output  16  current signed bias value

## Operation
- States: CALIB, RUN. Reset enters CALIB.
- Reset values: acc_out=0, acc_valid=0, calib_done=0, bias_out=0, accumulator=0, sample counter=0.
- CALIB behaviour:
  - Each raw_valid sign-extends raw_in to 16+CALIB_LOG2 bits and adds it to the accumulator; the counter increments.
  - acc_out stays 0 and acc_valid stays 0.
- Leaving CALIB:
  - On the 2^CALIB_LOG2-th sample, that sample is included in the sum.
  - bias_out is loaded with the sum arithmetically shifted right by CALIB_LOG2 bits, which rounds toward minus infinity.
  - At the same time the accumulator and counter clear, calib_done is set and the state goes to RUN.
  - That final sample produces no acc_valid.
- RUN behaviour, on each raw_valid:
  - Compute diff = raw_in - bias_out in 17-bit signed.
  - Saturate diff to [-32768, 32767].
  - If |diff| <= DEADBAND, force the result to 0.
  - Register the result into acc_out and pulse acc_valid.
- Between samples acc_out holds its last value. It does not return to 0.
- recal (any state, highest priority after reset):
  - Next state is CALIB; accumulator and counter clear.
  - calib_done clears, acc_out clears to 0, acc_valid is 0.
  - bias_out keeps its old value until the new calibration completes.
  - A raw_valid in the same cycle as recal is discarded.
- recal while already in CALIB restarts the count from zero.
- Asserting reset at any point, including mid-calibration, returns every register to its reset value immediately.

## Timing
- Latency: raw_valid/raw_in sampled at edge n produces acc_out/acc_valid at edge n+1, i.e. one register stage. No combinational path from inputs to outputs.
- Throughput: one sample per clock sustained, in both states.
- Calibration end:
  - calib_done and bias_out update on the edge that samples the last calibration sample.
  - The first conditioned output comes from the next raw_valid, one cycle after it.
- recal: outputs are cleared on the edge that samples recal; calibration counting resumes with the next cycle's raw_valid.
- The downstream integrator latches acc_out every clock regardless of acc_valid. A held value is therefore integrated every cycle by design.

## Test plan
All scenarios use CALIB_LOG2=2 and DEADBAND=8.
- Basic calibration and output:
  - Stimulus: reset, then raw 100, 102, 98, 104 with valid.
  - Required: bias_out=101 and calib_done=1 one cycle after the 4th sample.
  - Then raw 200 -> acc_out=99 with a single acc_valid pulse one cycle later; acc_out holds 99 afterwards.
- Deadband:
  - Stimulus: bias 101, then raw 109, 93, 110.
  - Required: acc_out 0, 0, 9.
  - Repeat with raw 92 -> acc_out -9.
- Saturation:
  - Positive limit: calibrate with four samples of -32768, then raw 32767 -> acc_out=32767.
  - Negative limit: calibrate with four samples of 32767, then raw -32768 -> acc_out=-32768.
- Negative bias rounding:
  - Stimulus: calibration samples -1, -1, -1, -2 (sum -5).
  - Required: bias_out=-2 (0xFFFE); raw 0 -> acc_out=0 (deadband); raw 20 -> acc_out=22.
- Recal mid-run:
  - Stimulus: in RUN with acc_out=99, pulse recal together with raw_valid.
  - Required: next cycle acc_out=0, calib_done=0, bias_out still 101, and the concurrent sample is ignored.
  - Then feed 4 samples of 50 -> bias_out=50.
- Reset mid-calibration, back-to-back valid:
  - Stimulus: after 2 of 4 samples, assert reset asynchronously.
  - Required: all outputs 0 immediately, and 4 further samples are needed to finish calibration.
  - Also check that continuous raw_valid every cycle yields acc_valid every cycle in RUN.
